// File: rtl/stage_sequencer.sv
// Multicycle stage-strobe sequencer: one-hot load strobes per stage after an
// instruction fetch, with an optional data-memory wait, stall/flush and timeout.
module stage_sequencer #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned MEM_STAGE  = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inst_resp,
  input  logic                          data_resp,
  input  logic                          data_read,
  input  logic                          data_write,
  input  logic                          stall,
  input  logic                          flush,
  output logic [NUM_STAGES-1:0]         load_stage,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic                          busy,
  output logic                          mem_wait,
  output logic                          mem_timeout,
  output logic [CNT_W-1:0]              retired
);

  localparam int unsigned IW = $clog2(NUM_STAGES);
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);
  localparam logic [IW-1:0] MEM_IDX   = IW'(MEM_STAGE);
  localparam logic [IW-1:0] AFTER_MEM = IW'(MEM_STAGE + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [NUM_STAGES-1:0] ONE = NUM_STAGES'(1);

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT} state_t;

  state_t        state;
  logic [IW-1:0] cur;
  logic [WW-1:0] wait_cnt;
  logic          mem_req;

  assign mem_req = data_read | data_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      retired     <= '0;
    end else if (flush) begin
      state       <= IDLE;
      cur         <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!stall && inst_resp) begin
            state <= RUN;
            cur   <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (cur == LAST_IDX) begin
              retired <= retired + CNT_W'(1);
              cur     <= '0;
              // back-to-back: a fetch response on the last strobe restarts at once
              if (!inst_resp) state <= IDLE;
            end else if (cur == MEM_IDX && mem_req && !data_resp) begin
              state    <= MEM_WAIT;
              wait_cnt <= '0;
            end else begin
              cur <= cur + IW'(1);
            end
          end
        end
        MEM_WAIT: begin
          // stall is deliberately ignored here so the timeout keeps running
          if (data_resp) begin
            state <= RUN;
            cur   <= AFTER_MEM;
          end else if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
            state       <= IDLE;
            cur         <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cur   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    load_stage = '0;
    if (state == RUN && !stall) load_stage = ONE << cur;
  end

  assign stage_idx = cur;
  assign busy      = (state != IDLE);
  assign mem_wait  = (state == MEM_WAIT);

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised successor to the multicycle stage-strobe generator.
- Emits a one-cycle, one-hot load strobe to each of NUM_STAGES datapath stages in order, starting from an instruction-fetch response.
- Differences from the previous generation: a variable-latency wait on data-memory response in a configurable stage, stall and flush control, a memory-wait timeout and a retired-instruction counter.
- Sits between the cache/memory handshakes and the datapath load enables of the multicycle core.

Parameters:
- NUM_STAGES, 4, number of strobed stages after fetch (decode, execute, memory, writeback by default); legal range 2..16.
- MEM_STAGE, 2, index of the stage that may wait on data_resp; must satisfy MEM_STAGE < NUM_STAGES-1.
- TIMEOUT, 255, maximum MEM_WAIT cycles before abort; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all logic samples on its rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_resp  in  1  instruction fetch complete; starts a sequence.
- data_resp  in  1  data memory response; ends a memory wait.
- data_read  in  1  datapath requests a data read (sampled in MEM_STAGE strobe cycle and during MEM_WAIT).
- data_write  in  1  datapath requests a data write (sampled like data_read).
- stall  in  1  freezes sequencing and suppresses strobes.
- flush  in  1  aborts the current sequence.
- load_stage  out  NUM_STAGES  one-hot load strobes; bit k loads stage k.
- stage_idx  out  $clog2(NUM_STAGES)  index of the pending/current stage; 0 when idle.
- busy  out  1  high whenever state is not IDLE.
- mem_wait  out  1  high while in MEM_WAIT.
- mem_timeout  out  1  sticky abort flag.
- retired  out  CNT_W  count of completed sequences.

Behaviour:
- Reset (rst high at an edge): state=IDLE, cur=0, wait counter=0, mem_timeout=0, retired=0. Reset priority is above all other inputs. Reset mid-sequence or mid-wait aborts with no further strobes.
- Priority per edge: rst > flush > stall > normal sequencing.
- States are IDLE, RUN and MEM_WAIT. cur is a stage index register.
- Output decode (combinational from registers and stall): load_stage = onehot(cur) when state==RUN and !stall, else all zero. At most one bit is ever high. busy = state!=IDLE. mem_wait = state==MEM_WAIT. stage_idx = cur.
- IDLE:
  - inst_resp at an edge -> RUN with cur=0.
  - The load_stage[0] strobe appears the following cycle, giving 1-cycle latency.
- RUN with stall=1: hold state and cur. The strobe is suppressed and remains pending.
- RUN with a strobe issued (stall=0), cur=k:
  - k<NUM_STAGES-1 and k!=MEM_STAGE -> cur=k+1 next cycle.
  - k==MEM_STAGE with (data_read|data_write)=1 and data_resp=1 in the same cycle -> cur=k+1 with no wait.
  - k==MEM_STAGE with (data_read|data_write)=1 and data_resp=0 -> MEM_WAIT, wait counter=0.
  - k==MEM_STAGE with no request -> cur=k+1.
  - k==NUM_STAGES-1 -> retired+1 (wraps modulo 2^CNT_W). If inst_resp is high in this cycle, go to RUN with cur=0 (back-to-back sequence). Otherwise go to IDLE.
- inst_resp in RUN or MEM_WAIT is ignored, except in the last-stage strobe cycle as above.
- MEM_WAIT:
  - No strobes are issued.
  - stall does not freeze the wait counter.
  - data_resp=1 -> RUN with cur=MEM_STAGE+1. Its strobe appears the next cycle (stall permitting).
  - Otherwise the wait counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no data_resp -> mem_timeout=1, state=IDLE, cur=0, retired unchanged.
  - data_resp on the same edge the timeout would fire: the response wins and no timeout occurs.
- flush at an edge: state=IDLE, cur=0, wait counter=0, mem_timeout cleared. inst_resp in the same cycle is ignored. retired is unchanged.
- mem_timeout clears only on rst or flush. A new inst_resp after a timeout is accepted normally.
- With NUM_STAGES=4 and MEM_STAGE=2, the no-wait, no-stall behaviour is cycle-identical to the previous generation: decode, execute, memory and writeback strobes on consecutive cycles.

Test Plan:
- Basic sequence: defaults, inst_resp pulse at cycle 0 -> load_stage = 0001, 0010, 0100, 1000 on cycles 1-4; 0000 on cycle 5; busy high cycles 1-4; retired=1.
- Memory wait: data_read=1 during the 0100 strobe, data_resp at cycle 3 after the strobe -> mem_wait high 3 cycles, 1000 strobe on the following cycle, no other strobes in between.
- Back-to-back: inst_resp held high continuously -> pattern 0001, 0010, 0100, 1000 repeats with no idle gap; retired=3 after 12 strobe cycles.
- Stall: stall high for 2 cycles while 0010 is pending -> 0000 for 2 cycles, then 0010 once, then 0100; no stage skipped or repeated.
- Timeout: TIMEOUT=4, data_write=1 at MEM_STAGE, no data_resp -> mem_timeout=1 after 4 wait cycles, IDLE, retired unchanged. A subsequent flush clears mem_timeout.
- Flush and reset: flush during the 0010 strobe cycle -> 0000 next cycle, busy=0. rst during MEM_WAIT -> all outputs 0 next cycle; retired=0.
- Parameter variant: NUM_STAGES=6, MEM_STAGE=3 -> six consecutive one-hot strobes 000001 through 100000, with the wait inserted only after bit 3.
